// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 DIT FFT control sequencer.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fft_state_t;

    localparam int unsigned FFT_LOG2N_DEF    = 5;
    localparam int unsigned FFT_PIPE_LAT_DEF = 10;

    // Bits needed to hold any value 0..max_val (at least one bit).
    function automatic int unsigned fft_addr_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with synchronous clear; carries the write side
// of each butterfly issue across the arithmetic pipeline.
module fft_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT over a two-bank
// ping-pong memory, with twiddle addressing and latency-matched write-back.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N    = FFT_LOG2N_DEF,
    parameter int unsigned PIPE_LAT = FFT_PIPE_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inverse,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] twiddle_addr,
    output logic             twiddle_conj,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic             wr_en,
    output logic             bank_sel,
    output logic             result_bank
);

    localparam int unsigned SW  = fft_addr_w(LOG2N - 1);
    localparam int unsigned DW  = fft_addr_w(PIPE_LAT - 1);
    localparam int unsigned JW  = LOG2N - 1;
    localparam int unsigned TW  = LOG2N - 1;
    localparam int unsigned DLW = 1 + 2 * LOG2N;

    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);
    localparam logic [JW-1:0] J_LAST = '1;

    fft_state_t       r_state;
    fft_state_t       w_state_nxt;
    logic [SW-1:0]    r_stage;
    logic [JW-1:0]    r_j;
    logic [DW-1:0]    r_drain;
    logic             r_bank;
    logic             r_conj;

    logic             w_issue;
    logic [LOG2N-1:0] w_j_ext;
    logic [LOG2N-1:0] w_span;
    logic [LOG2N-1:0] w_pos;
    logic [LOG2N-1:0] w_a;
    logic [LOG2N-1:0] w_b;
    logic [LOG2N-1:0] w_tw_full;
    logic [DLW-1:0]   w_dl_in;
    logic [DLW-1:0]   w_dl_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = ISSUE;
            ISSUE:   if (r_j == J_LAST) w_state_nxt = DRAIN;
            DRAIN:   if (r_drain == D_LAST) w_state_nxt = (r_stage == S_LAST) ? DONE : ISSUE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_j is exactly N/2 wide, so it wraps to 0 on the last issue of a stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
            r_j     <= '0;
            r_drain <= '0;
            r_bank  <= 1'b0;
            r_conj  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_stage <= '0;
                        r_j     <= '0;
                        r_drain <= '0;
                        r_bank  <= 1'b0;
                        r_conj  <= inverse;
                    end
                end
                ISSUE: begin
                    r_j <= r_j + 1'b1;
                end
                DRAIN: begin
                    if (r_drain == D_LAST) begin
                        r_drain <= '0;
                        r_bank  <= ~r_bank;
                        r_stage <= (r_stage == S_LAST) ? '0 : r_stage + 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // a = ((j >> s) << (s+1)) | pos, written as a mask-and-shift so the
    // shift amount never needs more bits than the stage counter holds.
    always_comb begin
        w_j_ext   = {1'b0, r_j};
        w_span    = LOG2N'(1) << r_stage;
        w_pos     = w_j_ext & (w_span - 1'b1);
        w_a       = ((w_j_ext & ~(w_span - 1'b1)) << 1) | w_pos;
        w_b       = w_a + w_span;
        w_tw_full = w_pos << (S_LAST - r_stage);
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            ISSUE: begin
                busy    = 1'b1;
                w_issue = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
        rd_addr_a    = w_issue ? w_a : '0;
        rd_addr_b    = w_issue ? w_b : '0;
        twiddle_addr = w_issue ? TW'(w_tw_full) : '0;
    end

    assign w_dl_in = {w_issue, rd_addr_a, rd_addr_b};

    fft_delay_line #(
        .WIDTH (DLW),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .i_clk  (clk),
        .i_clr  (rst),
        .i_data (w_dl_in),
        .o_data (w_dl_out)
    );

    assign wr_en        = w_dl_out[DLW-1];
    assign wr_addr_a    = w_dl_out[2*LOG2N-1:LOG2N];
    assign wr_addr_b    = w_dl_out[LOG2N-1:0];
    assign bank_sel     = r_bank;
    assign twiddle_conj = r_conj;
    assign result_bank  = 1'(LOG2N % 2);

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer: timing, start/reset handling and a
// butterfly memory model whose results are compared with a direct DFT.
module tb_fft_sequencer;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rs [4];
    logic st [4];
    logic iv [4];

    logic       d0_busy, d0_done, d0_cj, d0_we, d0_bank, d0_res;
    logic [4:0] d0_ra, d0_rb, d0_wa, d0_wb;
    logic [3:0] d0_tw;
    logic       d1_busy, d1_done, d1_cj, d1_we, d1_bank, d1_res;
    logic [2:0] d1_ra, d1_rb, d1_wa, d1_wb;
    logic [1:0] d1_tw;
    logic       d2_busy, d2_done, d2_cj, d2_we, d2_bank, d2_res;
    logic [5:0] d2_ra, d2_rb, d2_wa, d2_wb;
    logic [4:0] d2_tw;
    logic       d3_busy, d3_done, d3_cj, d3_we, d3_bank, d3_res;
    logic [1:0] d3_ra, d3_rb, d3_wa, d3_wb;
    logic [0:0] d3_tw;

    fft_sequencer u_d0 (
        .clk(clk), .rst(rs[0]), .start(st[0]), .inverse(iv[0]),
        .busy(d0_busy), .done(d0_done), .rd_addr_a(d0_ra), .rd_addr_b(d0_rb),
        .twiddle_addr(d0_tw), .twiddle_conj(d0_cj), .wr_addr_a(d0_wa), .wr_addr_b(d0_wb),
        .wr_en(d0_we), .bank_sel(d0_bank), .result_bank(d0_res)
    );

    fft_sequencer #(.LOG2N(3), .PIPE_LAT(4)) u_d1 (
        .clk(clk), .rst(rs[1]), .start(st[1]), .inverse(iv[1]),
        .busy(d1_busy), .done(d1_done), .rd_addr_a(d1_ra), .rd_addr_b(d1_rb),
        .twiddle_addr(d1_tw), .twiddle_conj(d1_cj), .wr_addr_a(d1_wa), .wr_addr_b(d1_wb),
        .wr_en(d1_we), .bank_sel(d1_bank), .result_bank(d1_res)
    );

    fft_sequencer #(.LOG2N(6), .PIPE_LAT(3)) u_d2 (
        .clk(clk), .rst(rs[2]), .start(st[2]), .inverse(iv[2]),
        .busy(d2_busy), .done(d2_done), .rd_addr_a(d2_ra), .rd_addr_b(d2_rb),
        .twiddle_addr(d2_tw), .twiddle_conj(d2_cj), .wr_addr_a(d2_wa), .wr_addr_b(d2_wb),
        .wr_en(d2_we), .bank_sel(d2_bank), .result_bank(d2_res)
    );

    fft_sequencer #(.LOG2N(2), .PIPE_LAT(1)) u_d3 (
        .clk(clk), .rst(rs[3]), .start(st[3]), .inverse(iv[3]),
        .busy(d3_busy), .done(d3_done), .rd_addr_a(d3_ra), .rd_addr_b(d3_rb),
        .twiddle_addr(d3_tw), .twiddle_conj(d3_cj), .wr_addr_a(d3_wa), .wr_addr_b(d3_wb),
        .wr_en(d3_we), .bank_sel(d3_bank), .result_bank(d3_res)
    );

    int  n_chk  = 0;
    int  n_fail = 0;
    int  hz_err = 0;

    real x_re [64];
    real x_im [64];
    real ref_re [64];
    real ref_im [64];
    real m_re [2][64];
    real m_im [2][64];
    real q_ar [$];
    real q_ai [$];
    real q_br [$];
    real q_bi [$];

    int   h_ra, h_rb, h_tw, h_wa, h_wb, h_n;
    logic h_busy, h_done, h_cj, h_we, h_bank;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bitrev(input int k, input int lg);
        int r;
        r = 0;
        for (int i = 0; i < lg; i++) begin
            if (((k >> i) & 1) == 1) r = r | (1 << (lg - 1 - i));
        end
        return r;
    endfunction

    task automatic compute_ref(input int n);
        real sr, si, ang;
        for (int k = 0; k < n; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int m = 0; m < n; m++) begin
                ang = -2.0 * PI * real'(m * k) / real'(n);
                sr = sr + x_re[m] * $cos(ang) - x_im[m] * $sin(ang);
                si = si + x_re[m] * $sin(ang) + x_im[m] * $cos(ang);
            end
            ref_re[k] = sr;
            ref_im[k] = si;
        end
    endtask

    task automatic load(input int lg, input bit from_ref);
        int r;
        q_ar.delete(); q_ai.delete(); q_br.delete(); q_bi.delete();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 64; k++) begin
                m_re[b][k] = 0.0;
                m_im[b][k] = 0.0;
            end
        end
        for (int k = 0; k < (1 << lg); k++) begin
            r = bitrev(k, lg);
            m_re[0][r] = from_ref ? ref_re[k] : x_re[k];
            m_im[0][r] = from_ref ? ref_im[k] : x_im[k];
        end
    endtask

    task automatic sample(input int sel);
        case (sel)
            0: begin
                h_ra = int'(d0_ra); h_rb = int'(d0_rb); h_tw = int'(d0_tw);
                h_wa = int'(d0_wa); h_wb = int'(d0_wb); h_n = 32;
                h_busy = d0_busy; h_done = d0_done; h_cj = d0_cj; h_we = d0_we; h_bank = d0_bank;
            end
            1: begin
                h_ra = int'(d1_ra); h_rb = int'(d1_rb); h_tw = int'(d1_tw);
                h_wa = int'(d1_wa); h_wb = int'(d1_wb); h_n = 8;
                h_busy = d1_busy; h_done = d1_done; h_cj = d1_cj; h_we = d1_we; h_bank = d1_bank;
            end
            default: begin
                h_ra = int'(d2_ra); h_rb = int'(d2_rb); h_tw = int'(d2_tw);
                h_wa = int'(d2_wa); h_wb = int'(d2_wb); h_n = 64;
                h_busy = d2_busy; h_done = d2_done; h_cj = d2_cj; h_we = d2_we; h_bank = d2_bank;
            end
        endcase
    endtask

    // Butterfly + two-bank memory model driven by the sampled DUT addresses.
    task automatic step_h();
        real ang, c, s, br, bi, tr, ti;
        int  bk;
        bk = (h_bank === 1'b1) ? 1 : 0;
        if (h_we === 1'b1) begin
            if (q_ar.size() == 0) begin
                hz_err++;
            end else begin
                m_re[1-bk][h_wa] = q_ar.pop_front();
                m_im[1-bk][h_wa] = q_ai.pop_front();
                m_re[1-bk][h_wb] = q_br.pop_front();
                m_im[1-bk][h_wb] = q_bi.pop_front();
            end
        end
        if (h_ra != h_rb) begin
            ang = 2.0 * PI * real'(h_tw) / real'(h_n);
            if (h_cj !== 1'b1) ang = -ang;
            c  = $cos(ang);
            s  = $sin(ang);
            br = m_re[bk][h_rb];
            bi = m_im[bk][h_rb];
            tr = c * br - s * bi;
            ti = c * bi + s * br;
            q_ar.push_back(m_re[bk][h_ra] + tr);
            q_ai.push_back(m_im[bk][h_ra] + ti);
            q_br.push_back(m_re[bk][h_ra] - tr);
            q_bi.push_back(m_im[bk][h_ra] - ti);
        end
    endtask

    function automatic int cmp_ref(input int n, input int bk);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            if ((m_re[bk][k] - ref_re[k]) > 1e-6 || (ref_re[k] - m_re[bk][k]) > 1e-6 ||
                (m_im[bk][k] - ref_im[k]) > 1e-6 || (ref_im[k] - m_im[bk][k]) > 1e-6) bad++;
        end
        return bad;
    endfunction

    function automatic int cmp_scaled(input int n, input int bk);
        int bad;
        real er, ei;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            er = real'(n) * x_re[k];
            ei = real'(n) * x_im[k];
            if ((m_re[bk][k] - er) > 1e-6 || (er - m_re[bk][k]) > 1e-6 ||
                (m_im[bk][k] - ei) > 1e-6 || (ei - m_im[bk][k]) > 1e-6) bad++;
        end
        return bad;
    endfunction

    task automatic run(input int sel, input bit inv, output bit seen);
        seen = 1'b0;
        @(negedge clk);
        st[sel] = 1'b1;
        iv[sel] = inv;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            st[sel] = 1'b0;
            sample(sel);
            step_h();
            if (h_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int e_a, e_b, e_c, wcnt;
        bit seen;
        for (int k = 0; k < 64; k++) begin
            x_re[k] = real'((k * 7) % 13 - 6);
            x_im[k] = real'((k * 5) % 11 - 5);
        end
        rs = '{default: 1'b1};
        st = '{default: 1'b0};
        iv = '{default: 1'b0};
        repeat (3) @(negedge clk);
        rs = '{default: 1'b0};

        // Quiet after reset
        e_a = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (d0_busy !== 1'b0 || d0_done !== 1'b0 || d0_we !== 1'b0 || d0_bank !== 1'b0 ||
                d0_cj !== 1'b0 || d0_ra !== 5'd0 || d0_rb !== 5'd0 || d0_tw !== 4'd0 ||
                d0_wa !== 5'd0 || d0_wb !== 5'd0) e_a++;
        end
        chk("rst_quiet_cycles", e_a, 0);
        chk("rst_busy", d0_busy, 0);
        chk("rst_done", d0_done, 0);
        chk("rst_wr_en", d0_we, 0);
        chk("rst_rd_a", d0_ra, 0);
        chk("rst_rd_b", d0_rb, 0);
        chk("rst_twiddle", d0_tw, 0);
        chk("rst_wr_a", d0_wa, 0);
        chk("rst_bank_sel", d0_bank, 0);
        chk("rst_conj", d0_cj, 0);
        chk("result_bank_n32", d0_res, 1);

        // Reset in the middle of stage 1
        load(5, 1'b0);
        st[0] = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            st[0] = 1'b0;
            sample(0);
            step_h();
        end
        chk("pre_rst_wr_en", d0_we, 1);
        rs[0] = 1'b1;
        @(negedge clk);
        chk("post_rst_wr_en", d0_we, 0);
        chk("post_rst_busy", d0_busy, 0);
        rs[0] = 1'b0;
        @(negedge clk);

        // Full default-size run with ignored starts and an immediate restart
        compute_ref(32);
        load(5, 1'b0);
        st[0] = 1'b1;
        iv[0] = 1'b0;
        e_a = 0; e_b = 0; e_c = 0; wcnt = 0;
        for (int k = 1; k <= 140; k++) begin
            @(negedge clk);
            sample(0);
            step_h();
            if (h_busy !== ((k >= 1 && k <= 130) || k >= 133)) e_a++;
            if (h_done !== (k == 131)) e_b++;
            if (h_cj !== (k >= 133)) e_c++;
            if (k <= 131 && h_we === 1'b1) wcnt++;
            if (k == 1) begin
                chk("s0_j0_rd_a", d0_ra, 0);
                chk("s0_j0_rd_b", d0_rb, 1);
                chk("s0_j0_twiddle", d0_tw, 0);
            end
            if (k == 110) begin
                chk("s4_j5_rd_a", d0_ra, 5);
                chk("s4_j5_rd_b", d0_rb, 21);
                chk("s4_j5_twiddle", d0_tw, 5);
            end
            if (k == 131) chk("fft32_forward_bad_bins", cmp_ref(32, 1), 0);
            st[0] = (k == 40 || k == 131 || k == 132);
            iv[0] = (k >= 20);
        end
        chk("n32_busy_window", e_a, 0);
        chk("n32_done_pulse", e_b, 0);
        chk("n32_conj_latch", e_c, 0);
        chk("n32_wr_en_count", wcnt, 80);
        rs[0] = 1'b1;
        @(negedge clk);
        rs[0] = 1'b0;

        // LOG2N=3: forward then inverse
        compute_ref(8);
        load(3, 1'b0);
        run(1, 1'b0, seen);
        chk("n8_fwd_done_seen", seen, 1);
        chk("n8_fwd_bad_bins", cmp_ref(8, 1), 0);
        load(3, 1'b1);
        run(1, 1'b1, seen);
        chk("n8_inv_done_seen", seen, 1);
        chk("n8_inv_bad_points", cmp_scaled(8, 1), 0);
        chk("n8_conj", d1_cj, 1);
        chk("result_bank_n8", d1_res, 1);

        // LOG2N=6: forward then inverse
        compute_ref(64);
        load(6, 1'b0);
        run(2, 1'b0, seen);
        chk("n64_fwd_done_seen", seen, 1);
        chk("n64_fwd_bad_bins", cmp_ref(64, 0), 0);
        load(6, 1'b1);
        run(2, 1'b1, seen);
        chk("n64_inv_done_seen", seen, 1);
        chk("n64_inv_bad_points", cmp_scaled(64, 0), 0);
        chk("result_bank_n64", d2_res, 0);

        // LOG2N=2, PIPE_LAT=1: T=6
        @(negedge clk);
        st[3] = 1'b1;
        e_a = 0; e_b = 0; e_c = 0; wcnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            st[3] = 1'b0;
            if (d3_busy !== (k <= 6)) e_a++;
            if (d3_done !== (k == 7)) e_b++;
            if (d3_bank !== (k >= 4 && k <= 6)) e_c++;
            if (d3_we === 1'b1) wcnt++;
        end
        chk("n4_busy_window", e_a, 0);
        chk("n4_done_pulse", e_b, 0);
        chk("n4_bank_toggle", e_c, 0);
        chk("n4_wr_en_count", wcnt, 4);
        chk("result_bank_n4", d3_res, 0);

        chk("model_write_underflow", hz_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Parametrised control sequencer for an in-place, radix-2 decimation-in-time FFT of N = 2^LOG2N points. Given a start pulse, it runs all LOG2N stages: it issues one butterfly read per cycle to a two-bank ping-pong data memory, drives the twiddle ROM address, and replays the matching write addresses after a configurable pipeline latency. It also supports an inverse-transform mode and reports completion with a one-cycle done pulse. It replaces the fixed 32-point address generator and delay chain between the butterfly unit, the twiddle ROM and the two-bank memory.

## Interface
- LOG2N, 5, log2 of the transform length; legal range 2..10.
- PIPE_LAT, 10, cycles from read-address issue to the matching butterfly outputs arriving at the memory write port; legal range 1..31.
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  begin a transform; sampled only in IDLE.
- inverse  input  1  inverse-FFT select; latched on an accepted start.
- busy  output  1  high from the first issue cycle through the last write cycle.
- done  output  1  one-cycle pulse after the final write.
- rd_addr_a, rd_addr_b  output  LOG2N  butterfly read addresses.
- twiddle_addr  output  LOG2N-1  twiddle ROM address, aligned with the read addresses.
- twiddle_conj  output  1  latched inverse flag; tells the butterfly to conjugate the twiddle.
- wr_addr_a, wr_addr_b  output  LOG2N  read addresses delayed by PIPE_LAT cycles.
- wr_en  output  1  write enable, delayed by PIPE_LAT cycles.
- bank_sel  output  1  bank being read; writes go to ~bank_sel.
- result_bank  output  1  bank holding the final result; equals LOG2N mod 2.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE→ISSUE on start.
  - ISSUE→DRAIN after N/2 issues.
  - DRAIN→ISSUE after PIPE_LAT cycles if the stage is not the last one.
  - DRAIN→DONE after PIPE_LAT cycles if the stage is the last one.
  - DONE→IDLE after one cycle.
- Counters: stage s (0..LOG2N-1), butterfly index j (0..N/2-1), drain counter.
- Address rule for stage s, index j:
  - span = 2^s
  - pos = j & (span-1)
  - a = ((j >> s) << (s+1)) | pos
  - b = a + span
  - twiddle_addr = pos << (LOG2N-1-s)
  - All arithmetic is unsigned and the widths are exact, so no wrap occurs.
- Input data is expected in bit-reversed order in bank 0; output is in natural order in result_bank.
- bank_sel is 0 on start and toggles on the DRAIN→ISSUE/DONE transition.
- In IDLE, DRAIN and DONE the read addresses hold 0, and the issue-side write enable is 0.
- start while not in IDLE (including the DONE cycle) is ignored.
- inverse is ignored except on an accepted start.
- rst at any time:
  - FSM returns to IDLE.
  - All counters clear.
  - The delay line clears, so wr_en is 0 on the cycle after rst.
  - No partial stage is completed.
- Reset values: busy=0, done=0, wr_en=0, all addresses 0, bank_sel=0, twiddle_conj=0. result_bank is a constant.

## Timing
- Let the start-accept cycle be cycle 0.
- Stage s issues on cycles 1 + s·(N/2+PIPE_LAT) + j.
- Each issue has its write exactly PIPE_LAT cycles later.
- Each stage occupies N/2+PIPE_LAT cycles, so the next stage's first read never precedes the previous stage's last write.
- The last write occurs at cycle T = LOG2N·(N/2+PIPE_LAT).
- busy is high on cycles 1..T.
- done is high on cycle T+1 only, with busy=0.
- A new start is first accepted on cycle T+2.
- For N=32 and PIPE_LAT=10: T=130, done is on cycle 131.

## Structure
- Package fft_pkg holds:
  - the state enum;
  - the default LOG2N and PIPE_LAT constants;
  - an address-width helper function.
- One sub-module, fft_delay_line, has parameters WIDTH and DEPTH and a synchronous clear.
- It is instantiated once on the concatenation {wr_en, addr_a, addr_b}.

## Test plan
- Reset, then no start for 20 cycles → all outputs at their reset values; busy=0.
- Defaults, start at cycle 0 → busy on cycles 1..130, done only on cycle 131, wr_en high on exactly 80 cycles.
  - Stage 0 first pair is (0,1) with twiddle 0.
  - Stage 4, j=5 gives (5,21) with twiddle 5.
- Scoreboard a reference-model FFT over the memory model, forward then inverse(forward(x)), LOG2N=3 and 6 → inverse result matches N·x exactly for integer inputs.
- start pulsed on cycles 40 and 131 during a run → ignored; second start on cycle 132 → new busy from cycle 133.
- rst asserted on cycle 50 mid-stage → wr_en 0 and busy 0 on cycle 51; a subsequent start runs a full, correct transform.
- PIPE_LAT=1, LOG2N=2 → T=6, bank_sel toggles on cycles 3 and 6, result_bank=0.
